// File: rtl/code_rom_pkg.sv
// Shared types and widths for the byte-programmable code ROM loader.
package code_rom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } loader_state_e;

  localparam int BYTE_W     = 8;
  localparam int CHECKSUM_W = 8;

  // Running checksum step: plain modulo-256 byte sum.
  function automatic logic [CHECKSUM_W-1:0] checksum_add(
    input logic [CHECKSUM_W-1:0] sum,
    input logic [BYTE_W-1:0]     data
  );
    return sum + data;
  endfunction

endpackage

// File: rtl/code_rom_loader_if.sv
// Programming and fetch bus of the code ROM loader. The master side is the
// host/instruction-bus user, the slave side is the loader itself.
interface code_rom_loader_if #(
  parameter int ADDR_W  = 12,
  parameter int FETCH_W = 32
);
  logic              prog_mode;
  logic              prog_start;
  logic [ADDR_W-1:0] prog_base;
  logic              prog_valid;
  logic [7:0]        prog_data;
  logic              prog_last;
  logic              prog_ready;
  logic              prog_done;
  logic              prog_error;
  logic [ADDR_W:0]   prog_count;
  logic [7:0]        prog_checksum;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [FETCH_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_fault;

  modport master (
    output prog_mode, prog_start, prog_base, prog_valid, prog_data, prog_last,
    output fetch_req, fetch_addr,
    input  prog_ready, prog_done, prog_error, prog_count, prog_checksum,
    input  fetch_data, fetch_valid, fetch_fault
  );

  modport slave (
    input  prog_mode, prog_start, prog_base, prog_valid, prog_data, prog_last,
    input  fetch_req, fetch_addr,
    output prog_ready, prog_done, prog_error, prog_count, prog_checksum,
    output fetch_data, fetch_valid, fetch_fault
  );
endinterface

// File: rtl/code_rom_fetch.sv
// Little-endian instruction fetch: word assembly from the byte array, range
// and alignment faulting, and an optional one-cycle output register.
module code_rom_fetch
  import code_rom_pkg::*;
#(
  parameter int NUM_BYTES        = 32,
  parameter int ADDR_W           = 12,
  parameter int FETCH_W          = 32,
  parameter int FETCH_LATENCY    = 0,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en_i,
  input  logic [BYTE_W-1:0]  mem_i [NUM_BYTES],
  input  logic               fetch_req_i,
  input  logic [ADDR_W-1:0]  fetch_addr_i,
  output logic [FETCH_W-1:0] fetch_data_o,
  output logic               fetch_valid_o,
  output logic               fetch_fault_o
);

  localparam int FETCH_B = FETCH_W / BYTE_W;
  localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [ADDR_W:0] NUM_BYTES_P = (ADDR_W+1)'(NUM_BYTES);

  logic [FETCH_W-1:0] fetch_data_d, fetch_data_q;
  logic               fetch_fault_d, fetch_fault_q;
  logic               fetch_valid_d, fetch_valid_q;
  logic [ADDR_W:0]    byte_addr_s;
  logic               misaligned_s;

  // Assemble the fetched word and decide whether the access faults.
  always_comb begin
    fetch_data_d  = '0;
    fetch_fault_d = 1'b0;
    fetch_valid_d = fetch_req_i;
    byte_addr_s   = '0;
    misaligned_s  = (ALLOW_MISALIGNED == 0) &&
                    ((32'(fetch_addr_i) % 32'(FETCH_B)) != 32'd0);
    if (!fetch_req_i) begin
      fetch_fault_d = 1'b0;
    end else if (!fetch_en_i) begin
      fetch_fault_d = 1'b1;
    end else if (misaligned_s) begin
      fetch_fault_d = 1'b1;
    end else begin
      for (int i = 0; i < FETCH_B; i++) begin
        // One extra address bit so the last bytes of the space never wrap to 0.
        byte_addr_s = {1'b0, fetch_addr_i} + (ADDR_W+1)'(i);
        if (byte_addr_s < NUM_BYTES_P) begin
          fetch_data_d[i*BYTE_W +: BYTE_W] = mem_i[byte_addr_s[IDX_W-1:0]];
        end else begin
          fetch_fault_d = 1'b1;
        end
      end
    end
  end

  // Optional output stage; holds the result of the previous cycle's request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_data_q  <= '0;
      fetch_fault_q <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_data_q  <= fetch_data_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign fetch_data_o  = (FETCH_LATENCY == 0) ? fetch_data_d  : fetch_data_q;
  assign fetch_fault_o = (FETCH_LATENCY == 0) ? fetch_fault_d : fetch_fault_q;
  assign fetch_valid_o = (FETCH_LATENCY == 0) ? fetch_valid_d : fetch_valid_q;

endmodule

// File: rtl/code_rom_loader.sv
// Byte-programmable code memory: framed valid/ready load port with base
// address, auto-increment, overflow/abort errors and checksum, plus fetch port.
module code_rom_loader
  import code_rom_pkg::*;
#(
  parameter int NUM_BYTES        = 32,
  parameter int ADDR_W           = 12,
  parameter int FETCH_W          = 32,
  parameter int FETCH_LATENCY    = 0,
  parameter int ALLOW_MISALIGNED = 1
) (
  input logic                clk,
  input logic                reset_code_rom_n,
  code_rom_loader_if.slave   bus
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [ADDR_W:0] NUM_BYTES_P = (ADDR_W+1)'(NUM_BYTES);
  localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W+1)'(1);

  loader_state_e          state_q, state_d;
  logic [ADDR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic [CHECKSUM_W-1:0]  csum_q, csum_d;
  logic [BYTE_W-1:0]      mem_q [NUM_BYTES];

  logic                   start_s;
  logic                   wr_en_s;
  logic [IDX_W-1:0]       wr_idx_s;
  logic [BYTE_W-1:0]      wr_data_s;
  logic                   fetch_en_s;

  // A start pulse only counts while the host owns the memory.
  assign start_s = bus.prog_start & bus.prog_mode;

  // Loader FSM next state, pointer, counters and write strobe.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    csum_d    = csum_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = wr_ptr_q[IDX_W-1:0];
    wr_data_s = bus.prog_data;
    case (state_q)
      IDLE, ERROR: begin
        if (start_s) begin
          wr_ptr_d = {1'b0, bus.prog_base};
          count_d  = '0;
          csum_d   = '0;
          if ({1'b0, bus.prog_base} >= NUM_BYTES_P) begin
            state_d = ERROR;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        if (!bus.prog_mode) begin
          // Host released the memory mid-frame; keep what was written.
          state_d = ERROR;
        end else if (bus.prog_valid) begin
          if (wr_ptr_q >= NUM_BYTES_P) begin
            // Overflow byte is dropped without touching count or checksum.
            state_d = ERROR;
          end else begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + PTR_ONE;
            csum_d   = checksum_add(csum_q, bus.prog_data);
            if (bus.prog_last) begin
              state_d = DONE;
            end else begin
              state_d = LOAD;
            end
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Loader state, pointer and frame statistics.
  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
    end
  end

  // Byte array; reset clears the whole program.
  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_idx_s] <= wr_data_s;
    end
  end

  assign bus.prog_ready    = (state_q == LOAD);
  assign bus.prog_done     = (state_q == DONE);
  assign bus.prog_error    = (state_q == ERROR);
  assign bus.prog_count    = count_q;
  assign bus.prog_checksum = csum_q;

  // Fetch never overlaps a write: the host must release the memory first.
  assign fetch_en_s = !bus.prog_mode && ((state_q == IDLE) || (state_q == DONE));

  code_rom_fetch #(
    .NUM_BYTES        (NUM_BYTES),
    .ADDR_W           (ADDR_W),
    .FETCH_W          (FETCH_W),
    .FETCH_LATENCY    (FETCH_LATENCY),
    .ALLOW_MISALIGNED (ALLOW_MISALIGNED)
  ) u_fetch (
    .clk           (clk),
    .rst_n         (reset_code_rom_n),
    .fetch_en_i    (fetch_en_s),
    .mem_i         (mem_q),
    .fetch_req_i   (bus.fetch_req),
    .fetch_addr_i  (bus.fetch_addr),
    .fetch_data_o  (bus.fetch_data),
    .fetch_valid_o (bus.fetch_valid),
    .fetch_fault_o (bus.fetch_fault)
  );

endmodule

// File: tb/tb_code_rom_loader.sv
// Randomized bench for code_rom_loader: two instances (combinational fetch with
// misalignment allowed, registered fetch with misalignment faulting) share one
// stimulus stream and are checked against a byte-array reference model.
module tb_code_rom_loader;

  localparam int NB = 32;
  localparam int AW = 12;
  localparam int FW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          prog_mode, prog_start, prog_valid, prog_last, fetch_req;
  logic [AW-1:0] prog_base, fetch_addr;
  logic [7:0]    prog_data;

  code_rom_loader_if #(.ADDR_W(AW), .FETCH_W(FW)) bus_a ();
  code_rom_loader_if #(.ADDR_W(AW), .FETCH_W(FW)) bus_b ();

  assign bus_a.prog_mode  = prog_mode;   assign bus_b.prog_mode  = prog_mode;
  assign bus_a.prog_start = prog_start;  assign bus_b.prog_start = prog_start;
  assign bus_a.prog_base  = prog_base;   assign bus_b.prog_base  = prog_base;
  assign bus_a.prog_valid = prog_valid;  assign bus_b.prog_valid = prog_valid;
  assign bus_a.prog_data  = prog_data;   assign bus_b.prog_data  = prog_data;
  assign bus_a.prog_last  = prog_last;   assign bus_b.prog_last  = prog_last;
  assign bus_a.fetch_req  = fetch_req;   assign bus_b.fetch_req  = fetch_req;
  assign bus_a.fetch_addr = fetch_addr;  assign bus_b.fetch_addr = fetch_addr;

  code_rom_loader #(.NUM_BYTES(NB), .ADDR_W(AW), .FETCH_W(FW),
                    .FETCH_LATENCY(0), .ALLOW_MISALIGNED(1))
    dut_a (.clk(clk), .reset_code_rom_n(rst_n), .bus(bus_a));

  code_rom_loader #(.NUM_BYTES(NB), .ADDR_W(AW), .FETCH_W(FW),
                    .FETCH_LATENCY(1), .ALLOW_MISALIGNED(0))
    dut_b (.clk(clk), .reset_code_rom_n(rst_n), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] m_mem [NB];
  bit         m_err;
  int         m_cnt;
  logic [7:0] m_sum;

  logic [7:0] frame_q [$];
  int         fetch_q [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;
    m_err = 1'b0;
    m_cnt = 0;
    m_sum = 8'h00;
  endfunction

  // Returns {fault, data} for a fetch of FW/8 bytes starting at addr.
  function automatic logic [32:0] model_fetch(input int addr, input bit mis_ok, input bit en);
    logic [31:0] d;
    bit f;
    d = 32'h0;
    f = 1'b0;
    if (!en) f = 1'b1;
    else if (!mis_ok && (addr % 4) != 0) f = 1'b1;
    else begin
      for (int i = 0; i < 4; i++) begin
        if (addr + i < NB) d[8*i +: 8] = m_mem[addr + i];
        else f = 1'b1;
      end
    end
    return {f, d};
  endfunction

  task automatic check_prog(input string tag, input bit exp_ready, input bit exp_done);
    check_eq({tag, "/a_ready"}, bus_a.prog_ready, exp_ready);
    check_eq({tag, "/a_done"},  bus_a.prog_done,  exp_done);
    check_eq({tag, "/a_error"}, bus_a.prog_error, m_err);
    check_eq({tag, "/a_count"}, bus_a.prog_count, m_cnt);
    check_eq({tag, "/a_csum"},  bus_a.prog_checksum, m_sum);
    check_eq({tag, "/b_done"},  bus_b.prog_done,  exp_done);
    check_eq({tag, "/b_error"}, bus_b.prog_error, m_err);
    check_eq({tag, "/b_count"}, bus_b.prog_count, m_cnt);
    check_eq({tag, "/b_csum"},  bus_b.prog_checksum, m_sum);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "/a_ready"}, bus_a.prog_ready, 0);
    check_eq({tag, "/a_done"},  bus_a.prog_done, 0);
    check_eq({tag, "/a_error"}, bus_a.prog_error, 0);
    check_eq({tag, "/a_count"}, bus_a.prog_count, 0);
    check_eq({tag, "/a_csum"},  bus_a.prog_checksum, 0);
    check_eq({tag, "/a_fetch"}, {bus_a.fetch_valid, bus_a.fetch_fault, bus_a.fetch_data}, 0);
    check_eq({tag, "/b_prog"},  {bus_b.prog_ready, bus_b.prog_done, bus_b.prog_error,
                                 bus_b.prog_count, bus_b.prog_checksum}, 0);
    check_eq({tag, "/b_fetch"}, {bus_b.fetch_valid, bus_b.fetch_fault, bus_b.fetch_data}, 0);
  endtask

  // Called and returns at 1 time unit after a rising edge. Sends frame_q;
  // abort_at >= size means no abort, else prog_mode drops before that byte.
  task automatic run_frame(input string tag, input int base, input int abort_at);
    int  n;
    int  ptr;
    bit  m_done;
    n = frame_q.size();
    prog_mode  = 1'b1;
    prog_start = 1'b1;
    prog_base  = AW'(base);
    @(posedge clk); #1;
    prog_start = 1'b0;
    m_cnt  = 0;
    m_sum  = 8'h00;
    m_done = 1'b0;
    m_err  = (base >= NB);
    ptr    = base;
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        prog_mode = 1'b0;
        @(posedge clk); #1;
        m_err = 1'b1;
        break;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      prog_valid = 1'b1;
      prog_data  = frame_q[k];
      prog_last  = (k == n - 1);
      @(posedge clk); #1;
      prog_valid = 1'b0;
      prog_last  = 1'b0;
      if (!m_err) begin
        if (ptr >= NB) m_err = 1'b1;
        else begin
          m_mem[ptr] = frame_q[k];
          m_cnt++;
          m_sum = m_sum + frame_q[k];
          ptr++;
          if (k == n - 1) m_done = 1'b1;
        end
      end
    end
    if (m_done) begin
      check_prog({tag, "/done"}, 1'b0, 1'b1);
      prog_mode = 1'b0;
      @(posedge clk); #1;
      check_prog({tag, "/after"}, 1'b0, 1'b0);
    end else begin
      check_prog({tag, "/err"}, 1'b0, 1'b0);
      prog_mode = 1'b0;
    end
  endtask

  // One request per cycle from fetch_q; instance b answers one cycle later.
  task automatic fetch_burst(input string tag, input bit mode);
    int          n;
    bit          en;
    logic [32:0] ea, eb;
    logic [32:0] exp_b [$];
    n  = fetch_q.size();
    prog_mode = mode;
    en = !mode && !m_err;
    for (int c = 0; c <= n + 1; c++) begin
      if (c < n) begin
        fetch_req  = 1'b1;
        fetch_addr = AW'(fetch_q[c]);
        ea = model_fetch(fetch_q[c], 1'b1, en);
        exp_b.push_back(model_fetch(fetch_q[c], 1'b0, en));
      end else begin
        fetch_req = 1'b0;
        ea = 33'h0;
      end
      @(negedge clk);
      if (c < n) begin
        check_eq($sformatf("%s/a_valid@%0d", tag, fetch_q[c]), bus_a.fetch_valid, 1);
        check_eq($sformatf("%s/a_data@%0d", tag, fetch_q[c]), bus_a.fetch_data, ea[31:0]);
        check_eq($sformatf("%s/a_fault@%0d", tag, fetch_q[c]), bus_a.fetch_fault, ea[32]);
      end else if (c == n) begin
        check_eq({tag, "/a_idle"}, {bus_a.fetch_valid, bus_a.fetch_fault, bus_a.fetch_data}, 0);
      end
      if (c > 0 && c <= n) begin
        eb = exp_b.pop_front();
        check_eq($sformatf("%s/b_valid@%0d", tag, fetch_q[c-1]), bus_b.fetch_valid, 1);
        check_eq($sformatf("%s/b_data@%0d", tag, fetch_q[c-1]), bus_b.fetch_data, eb[31:0]);
        check_eq($sformatf("%s/b_fault@%0d", tag, fetch_q[c-1]), bus_b.fetch_fault, eb[32]);
      end else if (c == n + 1) begin
        check_eq({tag, "/b_idle"}, bus_b.fetch_valid, 0);
      end
      @(posedge clk); #1;
    end
    prog_mode = 1'b0;
  endtask

  initial begin
    int base, n, abort_at;
    rst_n = 1'b1;
    prog_mode = 1'b0; prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    prog_base = '0; prog_data = '0; fetch_req = 1'b0; fetch_addr = '0;
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: first program, checksum 0xB6.
    frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame("load0", 0, 99);
    check_eq("load0/count8", bus_a.prog_count, 8);
    check_eq("load0/csum_b6", bus_a.prog_checksum, 8'hB6);
    fetch_q = '{0, 4};
    fetch_burst("fetch0", 1'b0);
    fetch_req = 1'b1; fetch_addr = AW'(4);
    @(negedge clk);
    check_eq("fetch4_word", bus_a.fetch_data, 32'h0010_0093);
    check_eq("fetch4_fault", bus_a.fetch_fault, 0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;

    // Overflow at the top of memory.
    frame_q = '{8'hAA, 8'hBB, 8'hCC};
    run_frame("ovf", 30, 99);
    check_eq("ovf/count2", bus_a.prog_count, 2);
    check_eq("ovf/ready0", bus_b.prog_ready, 0);

    // Abort after two bytes, fetch blocked in error, then a clean reload.
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("abort", 8, 2);
    fetch_q = '{8};
    fetch_burst("fetch_err", 1'b0);
    frame_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    run_frame("reload", 12, 99);
    check_eq("reload/err_clr", bus_a.prog_error, 0);
    fetch_q = '{8, 30, 2, 0, 4, 12, 31};
    fetch_burst("fetch1", 1'b0);
    fetch_q = '{0, 4};
    fetch_burst("fetch_blk", 1'b1);

    // Randomized frames and fetch bursts.
    for (int t = 0; t < 30; t++) begin
      base = ($urandom_range(0, 3) == 0) ? $urandom_range(26, 40) : $urandom_range(0, 28);
      n = $urandom_range(1, 6);
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : 99;
      frame_q.delete();
      for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", t), base, abort_at);
      fetch_q.delete();
      repeat ($urandom_range(1, 5)) begin
        fetch_q.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(4090, 4095)
                                                       : $urandom_range(0, 36));
      end
      fetch_burst($sformatf("rndf%0d", t), ($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of a frame.
    prog_mode = 1'b1; prog_start = 1'b1; prog_base = AW'(0);
    @(posedge clk); #1;
    prog_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      prog_valid = 1'b1; prog_data = 8'(8'hA0 + k);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    prog_valid = 1'b0; prog_mode = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_prog("post_rst", 1'b0, 1'b0);
    fetch_q = '{0, 28};
    fetch_burst("post_rst_fetch", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
